node_mem_sequencer: RTL and testbench
=====================================

NODE_MEM_SEQUENCER -- requirements
Module: node_mem_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first: clock  in  1  system clock, rising edge; nrst  in  1  reset, synchronous, active-low.
REQ-002 go  in  1  host request to run one kernel pass; ignored while busy.
REQ-003 busy  out  1  high from accepted go until pass completes.
REQ-004 kern_en  out  1  one-cycle re-arm pulse to kernel; kern_start  out  1  one-cycle launch pulse to kernel.
REQ-005 kern_done  in  1  kernel completion level, held until next kern_en.
REQ-006 kern_address  in  16  kernel byte address; kern_wr_en  in  1  kernel write strobe; kern_wdata  in  16  kernel write data.
REQ-007 kern_rdata  out  16  combinational read word at kern_address.
REQ-008 host_valid  in  1, host_wr  in  1, host_addr  in  16, host_wdata  in  16  host access request.
REQ-009 host_ready  out  1  equals !busy; host_rdata  out  16, host_rvalid  out  1  registered read return.
REQ-010 err  out  1  sticky address-fault flag.

Function
REQ-011 Storage SHALL be 2048 x 8-bit bytes; a word at byte address A SHALL be little-endian: low byte A, high byte A+1.
REQ-012 Valid word address: A < 2048 and A[0] = 0; any other address is a fault: write dropped, read returns 16'h0000, err set.
REQ-013 Kernel reads SHALL be asynchronous (kern_rdata valid same cycle as kern_address); kernel writes commit on the rising edge where kern_wr_en = 1.
REQ-014 Kernel port SHALL access memory only while busy; kern_wr_en outside busy SHALL be ignored.
REQ-015 Host access accepted when host_valid & host_ready; write commits on that edge; read: host_rdata and host_rvalid = 1 on the following cycle; host_rvalid otherwise 0.
REQ-016 Sequencer FSM states: IDLE, EN, START, RUN, FIN.
REQ-017 IDLE: go = 1 -> EN, busy = 1, err cleared; else stay.
REQ-018 EN: kern_en = 1 for exactly this cycle -> START; kern_done SHALL be ignored here (stale from previous pass).
REQ-019 START: kern_start = 1 for exactly this cycle -> RUN.
REQ-020 RUN: wait for kern_done = 1 -> FIN; no timeout.
REQ-021 FIN: busy = 0 at next edge -> IDLE; go sampled in FIN SHALL be ignored.
REQ-022 Minimum go-to-busy-low latency: 4 cycles plus kernel run time; go asserted during busy SHALL not be queued.
REQ-023 Host request with host_valid = 1 while busy SHALL not be accepted and SHALL not alter memory.
REQ-024 Simultaneous go and host_valid in IDLE: host access accepted that edge, go also accepted; host read data SHALL reflect pre-run memory.

Reset
REQ-025 On nrst = 0 at rising edge: state IDLE; busy, kern_en, kern_start, host_rvalid, err = 0; host_rdata = 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset mid-RUN SHALL abort the pass; kernel re-armed only via next go (EN pulse).

Structure
REQ-028 Shared package SHALL hold MEM_DEPTH = 2048, MEM_WIDTH = 8, WORD_WIDTH = 16, sequencer state encoding.
REQ-029 Byte array with word read/write and fault detection SHALL be sub-module node_mem_array; sequencer and port mux in top.

Verification
REQ-030 Host write 16'hBEEF to 16'h068A, read back -> host_rdata = 16'hBEEF one cycle later, bytes 0x68A = EF, 0x68B = BE.
REQ-031 go with kernel model asserting done 10 cycles after start -> kern_en cycle 1, kern_start cycle 2, busy low 1 cycle after done seen.
REQ-032 Kernel write 16'h0005 to 16'h068E during RUN, then host read -> 16'h0005; host_valid during RUN -> host_ready = 0, no write.
REQ-033 Host write to 16'h0801 and to 16'h0803 -> err = 1, memory unchanged, read returns 16'h0000; next go clears err.
REQ-034 Stale kern_done = 1 held from prior pass, new go -> FSM does not leave before RUN, completes only on fresh done.
REQ-035 nrst low during RUN -> busy = 0, state IDLE next cycle, previously written memory word retained.

Source files
------------

// File: rtl/node_mem_sequencer_pkg.sv
// Shared definitions for the node memory sequencer: memory geometry,
// sequencer state encoding and the word-address legality helper.
package node_mem_sequencer_pkg;

  localparam int MEM_DEPTH       = 2048;
  localparam int MEM_WIDTH       = 8;
  localparam int WORD_WIDTH      = 16;
  localparam int ADDR_WIDTH      = 16;
  localparam int BYTE_ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_EN    = 3'd1,
    SEQ_START = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_FIN   = 3'd4
  } seq_state_e;

  // A word access is legal only when it is inside the array and halfword aligned.
  function automatic logic word_addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return (addr < 16'(MEM_DEPTH)) && (addr[0] == 1'b0);
  endfunction

endpackage

// File: rtl/node_mem_sequencer_array.sv
// Byte-organised storage with a single little-endian word port.
// Reads are combinational; writes commit on the rising clock edge.
// Illegal addresses drop the write, read as zero and raise fault.
module node_mem_array
  import node_mem_sequencer_pkg::*;
(
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  fault
);

  // Contents are deliberately never reset so data survives a sequencer abort.
  logic [MEM_WIDTH-1:0]       mem_q [MEM_DEPTH];
  logic [BYTE_ADDR_WIDTH-1:0] lo_idx;
  logic [BYTE_ADDR_WIDTH-1:0] hi_idx;

  // Decode byte lanes, flag illegal addresses and assemble the read word.
  always_comb begin
    fault  = !word_addr_ok(addr);
    lo_idx = {addr[BYTE_ADDR_WIDTH-1:1], 1'b0};
    hi_idx = {addr[BYTE_ADDR_WIDTH-1:1], 1'b1};
    if (fault) begin
      rdata = 16'h0000;
    end else begin
      rdata = {mem_q[hi_idx], mem_q[lo_idx]};
    end
  end

  // Commit both bytes of a legal word write; faulting writes are dropped.
  always_ff @(posedge clock) begin
    if (wr_en && !fault) begin
      mem_q[lo_idx] <= wdata[7:0];
      mem_q[hi_idx] <= wdata[15:8];
    end
  end

endmodule

// File: rtl/node_mem_sequencer.sv
// Kernel-pass sequencer with a shared node memory. The host owns the memory
// port while idle; the kernel owns it for the whole pass (busy high).
module node_mem_sequencer
  import node_mem_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        nrst,
  input  logic        go,
  output logic        busy,
  output logic        kern_en,
  output logic        kern_start,
  input  logic        kern_done,
  input  logic [15:0] kern_address,
  input  logic        kern_wr_en,
  input  logic [15:0] kern_wdata,
  output logic [15:0] kern_rdata,
  input  logic        host_valid,
  input  logic        host_wr,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ready,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic        err
);

  seq_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        kern_en_q, kern_en_d;
  logic        kern_start_q, kern_start_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        err_q, err_d;

  logic        go_accept;
  logic        host_accept;
  logic        access_fault;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_fault;

  node_mem_array u_mem (
    .clock (clock),
    .addr  (mem_addr),
    .wr_en (mem_wr_en),
    .wdata (mem_wdata),
    .rdata (mem_rdata),
    .fault (mem_fault)
  );

  // Memory port ownership: kernel while busy, host otherwise.
  always_comb begin
    host_accept = host_valid & ~busy_q;
    if (busy_q) begin
      mem_addr  = kern_address;
      mem_wr_en = kern_wr_en;
      mem_wdata = kern_wdata;
    end else begin
      mem_addr  = host_addr;
      mem_wr_en = host_accept & host_wr;
      mem_wdata = host_wdata;
    end
  end

  // Sequencer next state; EN and START are single unconditional cycles so a
  // stale kern_done from the previous pass can only be seen once in RUN.
  always_comb begin
    state_d   = state_q;
    go_accept = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (go) begin
          state_d   = SEQ_EN;
          go_accept = 1'b1;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_EN:    state_d = SEQ_START;
      SEQ_START: state_d = SEQ_RUN;
      SEQ_RUN: begin
        if (kern_done) begin
          state_d = SEQ_FIN;
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_FIN:   state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
    busy_d       = (state_d != SEQ_IDLE);
    kern_en_d    = (state_d == SEQ_EN);
    kern_start_d = (state_d == SEQ_START);
  end

  // Host read return and sticky fault flag. Kernel reads are continuous and
  // carry no strobe, so only host accesses and kernel writes can raise err.
  // A fault on the go edge wins over the clear since it is the newer event.
  always_comb begin
    host_rvalid_d = host_accept & ~host_wr;
    if (host_rvalid_d) begin
      host_rdata_d = mem_rdata;
    end else begin
      host_rdata_d = host_rdata_q;
    end
    access_fault = mem_fault & (host_accept | (busy_q & kern_wr_en));
    if (access_fault) begin
      err_d = 1'b1;
    end else if (go_accept) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Register state and all outputs; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q       <= SEQ_IDLE;
      busy_q        <= 1'b0;
      kern_en_q     <= 1'b0;
      kern_start_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= 16'h0000;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      kern_en_q     <= kern_en_d;
      kern_start_q  <= kern_start_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      err_q         <= err_d;
    end
  end

  assign busy        = busy_q;
  assign kern_en     = kern_en_q;
  assign kern_start  = kern_start_q;
  assign host_ready  = ~busy_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign err         = err_q;
  assign kern_rdata  = busy_q ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_node_mem_sequencer.sv
// Directed self-checking bench for node_mem_sequencer.
module tb_node_mem_sequencer;

  logic        clock;
  logic        nrst;
  logic        go;
  logic        busy;
  logic        kern_en;
  logic        kern_start;
  logic        kern_done;
  logic [15:0] kern_address;
  logic        kern_wr_en;
  logic [15:0] kern_wdata;
  logic [15:0] kern_rdata;
  logic        host_valid;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ready;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  node_mem_sequencer dut (
    .clock        (clock),
    .nrst         (nrst),
    .go           (go),
    .busy         (busy),
    .kern_en      (kern_en),
    .kern_start   (kern_start),
    .kern_done    (kern_done),
    .kern_address (kern_address),
    .kern_wr_en   (kern_wr_en),
    .kern_wdata   (kern_wdata),
    .kern_rdata   (kern_rdata),
    .host_valid   (host_valid),
    .host_wr      (host_wr),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ready   (host_ready),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [15:0] d);
    host_valid = 1'b1; host_wr = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_valid = 1'b0; host_wr = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    host_valid = 1'b1; host_wr = 1'b0; host_addr = a;
    tick();
    host_valid = 1'b0;
    check_eq({tag, "_rvalid"}, {15'd0, host_rvalid}, 16'h0001);
    check_eq(tag, host_rdata, exp);
  endtask

  initial begin
    nrst = 1'b0; go = 1'b0; kern_done = 1'b0;
    kern_address = 16'h0000; kern_wr_en = 1'b0; kern_wdata = 16'h0000;
    host_valid = 1'b0; host_wr = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
    tick(); tick();

    // Reset state
    check_eq("rst_busy",   {15'd0, busy},        16'h0000);
    check_eq("rst_en",     {15'd0, kern_en},     16'h0000);
    check_eq("rst_start",  {15'd0, kern_start},  16'h0000);
    check_eq("rst_rvalid", {15'd0, host_rvalid}, 16'h0000);
    check_eq("rst_err",    {15'd0, err},         16'h0000);
    check_eq("rst_rdata",  host_rdata,           16'h0000);
    check_eq("rst_ready",  {15'd0, host_ready},  16'h0001);
    nrst = 1'b1;
    tick();

    // Host write/read, little-endian byte placement
    host_write(16'h068A, 16'hBEEF);
    host_read("rd_beef", 16'h068A, 16'hBEEF);
    check_eq("byte_68a", {8'h00, dut.u_mem.mem_q[11'h68A]}, 16'h00EF);
    check_eq("byte_68b", {8'h00, dut.u_mem.mem_q[11'h68B]}, 16'h00BE);
    tick();
    check_eq("rvalid_drop", {15'd0, host_rvalid}, 16'h0000);

    // Top-of-array boundary word
    host_write(16'h07FE, 16'hA55A);
    host_read("rd_top", 16'h07FE, 16'hA55A);

    // Address faults
    host_write(16'h0801, 16'h1234);
    check_eq("err_0801", {15'd0, err}, 16'h0001);
    host_write(16'h0803, 16'h5678);
    check_eq("err_0803", {15'd0, err}, 16'h0001);
    host_read("rd_fault", 16'h0801, 16'h0000);
    host_write(16'h068B, 16'h0000);
    host_read("rd_misalign_kept", 16'h068A, 16'hBEEF);
    host_read("rd_top_kept", 16'h07FE, 16'hA55A);

    // Kernel pass: EN, START, RUN with kernel write, done 10 cycles after start
    go = 1'b1;
    tick();
    go = 1'b0;
    check_eq("c1_en",    {15'd0, kern_en},    16'h0001);
    check_eq("c1_start", {15'd0, kern_start}, 16'h0000);
    check_eq("c1_busy",  {15'd0, busy},       16'h0001);
    check_eq("c1_ready", {15'd0, host_ready}, 16'h0000);
    check_eq("err_clr",  {15'd0, err},        16'h0000);
    tick();
    check_eq("c2_en",    {15'd0, kern_en},    16'h0000);
    check_eq("c2_start", {15'd0, kern_start}, 16'h0001);
    tick();
    check_eq("c3_start", {15'd0, kern_start}, 16'h0000);
    kern_address = 16'h068E; kern_wdata = 16'h0005; kern_wr_en = 1'b1;
    tick();
    kern_wr_en = 1'b0;
    #1;
    check_eq("kern_rdata", kern_rdata, 16'h0005);
    host_valid = 1'b1; host_wr = 1'b1; host_addr = 16'h068A; host_wdata = 16'h1111;
    #1;
    check_eq("run_ready", {15'd0, host_ready}, 16'h0000);
    tick();
    host_valid = 1'b0; host_wr = 1'b0;
    check_eq("run_rvalid", {15'd0, host_rvalid}, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("run_busy", {15'd0, busy}, 16'h0001);
    end
    go = 1'b1;
    kern_done = 1'b1;
    tick();
    check_eq("fin_busy", {15'd0, busy}, 16'h0001);
    tick();
    check_eq("idle_busy", {15'd0, busy},    16'h0000);
    check_eq("idle_en",   {15'd0, kern_en}, 16'h0000);
    go = 1'b0;
    tick();
    check_eq("no_queue",  {15'd0, busy},    16'h0000);
    host_read("rd_kwrite", 16'h068E, 16'h0005);
    host_read("rd_nowrite", 16'h068A, 16'hBEEF);
    check_eq("err_stay", {15'd0, err}, 16'h0000);

    // Stale done held, simultaneous go and host read
    go = 1'b1; host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h068E;
    tick();
    go = 1'b0; host_valid = 1'b0;
    check_eq("sim_rvalid", {15'd0, host_rvalid}, 16'h0001);
    check_eq("sim_rdata",  host_rdata,           16'h0005);
    check_eq("sim_en",     {15'd0, kern_en},     16'h0001);
    tick();
    check_eq("stale_start", {15'd0, kern_start}, 16'h0001);
    tick();
    check_eq("stale_run",   {15'd0, busy},       16'h0001);
    kern_done = 1'b0;
    kern_address = 16'h068E; kern_wdata = 16'h00AA; kern_wr_en = 1'b1;
    tick();
    kern_wr_en = 1'b0;
    tick(); tick();
    check_eq("fresh_wait", {15'd0, busy}, 16'h0001);
    kern_done = 1'b1;
    tick(); tick();
    check_eq("fresh_done", {15'd0, busy}, 16'h0000);
    host_read("rd_aa", 16'h068E, 16'h00AA);

    // Reset in the middle of RUN
    kern_done = 1'b0;
    host_write(16'h0803, 16'h0001);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    host_write(16'h0000, 16'h0000);
    check_eq("pre_rst_busy", {15'd0, busy}, 16'h0001);
    nrst = 1'b0;
    tick();
    check_eq("mrst_busy",   {15'd0, busy},        16'h0000);
    check_eq("mrst_ready",  {15'd0, host_ready},  16'h0001);
    check_eq("mrst_start",  {15'd0, kern_start},  16'h0000);
    check_eq("mrst_rdata",  host_rdata,           16'h0000);
    nrst = 1'b1;
    tick();
    check_eq("post_rst_en",   {15'd0, kern_en}, 16'h0000);
    check_eq("post_rst_busy", {15'd0, busy},    16'h0000);
    host_read("rd_retained", 16'h068A, 16'hBEEF);
    host_read("rd_retained_top", 16'h07FE, 16'hA55A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
